// File: rtl/mem_march_ctrl.sv
// mem_march_ctrl: four-pass March self-test over every byte of the SRAM bank
// array. The controller shares the single bank port with the host. A host
// request always wins the port, and the march freezes in place for every cycle
// in which the host owns it.
module mem_march_ctrl #(
    parameter int         NUM_BANKS = 20,
    parameter logic [7:0] PATTERN   = 8'h55
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_host_req,
    input  logic                 i_host_rw,
    input  logic [4:0]           i_host_bank,
    input  logic [8:0]           i_host_addr,
    input  logic [7:0]           i_host_wdata,
    output logic [NUM_BANKS-1:0] o_bank_cs,
    output logic [8:0]           o_mem_addr,
    output logic                 o_mem_rw,
    output logic [7:0]           o_mem_wdata,
    input  logic [7:0]           i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [15:0]          o_err_count,
    output logic [4:0]           o_first_err_bank,
    output logic [8:0]           o_first_err_addr
);

    localparam logic [4:0] LAST_BANK   = 5'(NUM_BANKS - 1);
    localparam logic [8:0] LAST_ADDR   = 9'h1FF;
    localparam logic [7:0] PATTERN_INV = ~PATTERN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_RW1,
        ST_RW2,
        ST_R3,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // March sequencer state. In the two read-then-write passes, phase selects
    // the slot: 0 = read slot, 1 = write slot.
    state_t     state_reg, state_next;
    logic [4:0] bank_reg,  bank_next;
    logic [8:0] addr_reg,  addr_next;
    logic       phase_reg, phase_next;

    // Bank and byte together form one linear index. This works because the
    // byte field wraps at 512 into the bank field.
    logic [13:0] lin_cur;
    logic [13:0] lin_inc;
    logic [13:0] lin_dec;
    logic        at_last;
    logic        at_first;

    logic stall;
    logic active;
    logic abort_now;
    logic start_now;

    // Access requested by the march in the current cycle.
    logic       march_issue;
    logic       march_rw;
    logic [7:0] march_wdata;
    logic       rd_issue;
    logic [7:0] rd_expect;

    // One-cycle compare pipeline: expected value and address of the last read.
    logic       cmp_valid_reg;
    logic [7:0] cmp_expect_reg;
    logic [4:0] cmp_bank_reg;
    logic [8:0] cmp_addr_reg;
    logic       mismatch;

    // Result registers.
    logic [15:0] err_count_reg;
    logic        first_valid_reg;
    logic [4:0]  first_bank_reg;
    logic [8:0]  first_addr_reg;
    logic        done_reg;

    logic [NUM_BANKS-1:0] host_cs;
    logic [NUM_BANKS-1:0] march_cs;

    assign stall     = i_host_req;
    assign active    = (state_reg != ST_IDLE);
    assign abort_now = i_abort && active;
    assign start_now = (state_reg == ST_IDLE) && i_start;

    assign lin_cur  = {bank_reg, addr_reg};
    assign lin_inc  = lin_cur + 14'd1;
    assign lin_dec  = lin_cur - 14'd1;
    assign at_last  = (bank_reg == LAST_BANK) && (addr_reg == LAST_ADDR);
    assign at_first = (lin_cur == 14'd0);

    // Decode bank indices to one-hot. A host bank index beyond the array
    // matches no bit, so it selects nothing.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_cs
            assign host_cs[gi]  = (i_host_bank == 5'(gi));
            assign march_cs[gi] = (bank_reg == 5'(gi));
        end
    endgenerate

    // Compute the next state, the walk address and the march access for this
    // cycle. A host stall leaves everything unchanged.
    always_comb begin
        state_next  = state_reg;
        bank_next   = bank_reg;
        addr_next   = addr_reg;
        phase_next  = phase_reg;
        march_issue = 1'b0;
        march_rw    = 1'b0;
        march_wdata = 8'h00;
        rd_issue    = 1'b0;
        rd_expect   = 8'h00;

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_W0;
                    bank_next  = 5'd0;
                    addr_next  = 9'd0;
                    phase_next = 1'b0;
                end
            end

            ST_W0: begin
                march_issue = !stall;
                march_rw    = 1'b1;
                march_wdata = PATTERN;
                if (!stall) begin
                    if (at_last) begin
                        state_next = ST_RW1;
                        bank_next  = 5'd0;
                        addr_next  = 9'd0;
                    end else begin
                        {bank_next, addr_next} = lin_inc;
                    end
                end
            end

            ST_RW1: begin
                march_issue = !stall;
                march_rw    = phase_reg;
                march_wdata = PATTERN_INV;
                rd_issue    = !stall && !phase_reg;
                rd_expect   = PATTERN;
                if (!stall) begin
                    phase_next = !phase_reg;
                    if (phase_reg) begin
                        // The descending pass starts from the address where
                        // this pass ends, so the address is not reloaded.
                        if (at_last) begin
                            state_next = ST_RW2;
                        end else begin
                            {bank_next, addr_next} = lin_inc;
                        end
                    end
                end
            end

            ST_RW2: begin
                march_issue = !stall;
                march_rw    = phase_reg;
                march_wdata = PATTERN;
                rd_issue    = !stall && !phase_reg;
                rd_expect   = PATTERN_INV;
                if (!stall) begin
                    phase_next = !phase_reg;
                    if (phase_reg) begin
                        // Ends on bank 0 / byte 0, where the last read pass starts.
                        if (at_first) begin
                            state_next = ST_R3;
                        end else begin
                            {bank_next, addr_next} = lin_dec;
                        end
                    end
                end
            end

            ST_R3: begin
                march_issue = !stall;
                march_rw    = 1'b0;
                rd_issue    = !stall;
                rd_expect   = PATTERN;
                if (!stall) begin
                    if (at_last) begin
                        state_next = ST_FLUSH;
                        bank_next  = 5'd0;
                        addr_next  = 9'd0;
                    end else begin
                        {bank_next, addr_next} = lin_inc;
                    end
                end
            end

            // Waits here while the last R3 read is compared.
            ST_FLUSH: begin
                if (!stall) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!stall) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort_now) begin
            state_next = ST_IDLE;
            phase_next = 1'b0;
        end
    end

    // Register the sequencer state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            bank_reg  <= 5'd0;
            addr_reg  <= 9'd0;
            phase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            bank_reg  <= bank_next;
            addr_reg  <= addr_next;
            phase_reg <= phase_next;
        end
    end

    // Port mux. The host has priority; otherwise the march drives the port
    // when it issues an access, and the port is idle the rest of the time.
    always_comb begin
        o_bank_cs   = '0;
        o_mem_addr  = 9'd0;
        o_mem_rw    = 1'b0;
        o_mem_wdata = 8'h00;
        if (i_host_req) begin
            o_bank_cs   = host_cs;
            o_mem_addr  = i_host_addr;
            o_mem_rw    = i_host_rw;
            o_mem_wdata = i_host_wdata;
        end else if (march_issue) begin
            o_bank_cs   = march_cs;
            o_mem_addr  = addr_reg;
            o_mem_rw    = march_rw;
            o_mem_wdata = march_wdata;
        end
    end

    // Latch the expected value and address of each march read for the compare
    // in the next cycle. An abort drops the pending compare.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmp_valid_reg  <= 1'b0;
            cmp_expect_reg <= 8'h00;
            cmp_bank_reg   <= 5'd0;
            cmp_addr_reg   <= 9'd0;
        end else begin
            cmp_valid_reg <= rd_issue && !abort_now;
            if (rd_issue) begin
                cmp_expect_reg <= rd_expect;
                cmp_bank_reg   <= bank_reg;
                cmp_addr_reg   <= addr_reg;
            end
        end
    end

    // The bank returns read data one cycle after the read. The compare runs
    // even if the host stalls the march in that cycle.
    assign mismatch = cmp_valid_reg && (i_mem_rdata != cmp_expect_reg) && !abort_now;

    // Count mismatches (saturating) and keep the location of the first one
    // since start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_count_reg   <= 16'd0;
            first_valid_reg <= 1'b0;
            first_bank_reg  <= 5'd0;
            first_addr_reg  <= 9'd0;
        end else if (start_now) begin
            err_count_reg   <= 16'd0;
            first_valid_reg <= 1'b0;
            first_bank_reg  <= 5'd0;
            first_addr_reg  <= 9'd0;
        end else if (mismatch) begin
            if (err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            if (!first_valid_reg) begin
                first_valid_reg <= 1'b1;
                first_bank_reg  <= cmp_bank_reg;
                first_addr_reg  <= cmp_addr_reg;
            end
        end
    end

    // Completion pulse. It rises in the cycle the sequencer returns to idle,
    // which is also the cycle o_busy falls. An abort or a stall in that cycle
    // suppresses or delays it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_DONE) && !stall && !i_abort;
        end
    end

    assign o_busy           = active;
    assign o_done           = done_reg;
    assign o_err_count      = err_count_reg;
    assign o_first_err_bank = first_bank_reg;
    assign o_first_err_addr = first_addr_reg;

endmodule

// File: doc/mem_march_ctrl.md
# mem_march_ctrl

Self-test sequencer and port arbiter for the SRAM bank array. Runs a four-pass March test over every byte of every bank and counts and locates mismatches. It shares the single bank port with the host (SPI command FSM) side. Host accesses always win, and the march stalls in place while the host owns the port.

## Interface
- NUM_BANKS, 20, number of 512-byte banks addressed by o_bank_cs
- PATTERN, 8'h55, background data byte; passes alternate PATTERN and ~PATTERN
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_start  in  1  one-cycle pulse; starts a march when idle
- i_abort  in  1  stops a running march
- i_host_req  in  1  host wants the port this cycle
- i_host_rw  in  1  host access type, 1 = write
- i_host_bank  in  5  host bank index
- i_host_addr  in  9  host byte address
- i_host_wdata  in  8  host write data
- o_bank_cs  out  NUM_BANKS  one-hot bank select, all-zero when port idle
- o_mem_addr  out  9  byte address within bank
- o_mem_rw  out  1  1 = write, 0 = read
- o_mem_wdata  out  8  write data
- i_mem_rdata  in  8  read data, registered by bank, valid 1 cycle after read issue
- o_busy  out  1  march in progress
- o_done  out  1  one-cycle pulse on march completion
- o_err_count  out  16  mismatch count, saturates at 16'hFFFF
- o_first_err_bank  out  5  bank of first mismatch
- o_first_err_addr  out  9  byte address of first mismatch

## Operation
- Port mux is combinational.
  - i_host_req=1: host fields drive the port; o_bank_cs = one-hot(i_host_bank), or zero if i_host_bank >= NUM_BANKS.
  - Otherwise the march drives the port when it issues an access, else the port is idle.
- Stall: every cycle with i_host_req=1 freezes march state, address and pass. The march issues no access that cycle.
- States:
  - IDLE: on i_start → W0; clears counters, sets first-error valid=0, address = bank 0 / byte 0.
  - W0: ascending, write PATTERN, 1 port cycle per byte.
  - RW1: ascending, per byte read (expect PATTERN), then write ~PATTERN, 2 port cycles.
  - RW2: descending from last bank/byte 511, read (expect ~PATTERN), then write PATTERN.
  - R3: ascending, read (expect PATTERN), 1 port cycle per byte.
  - FLUSH: one cycle for the final R3 compare.
  - DONE: pulses o_done for one cycle → IDLE.
- Address walk: byte 0..511 within a bank, then next bank. Last address is bank NUM_BANKS-1 / byte 511. The state advances after the last address's final access.
- Compare: every march read registers its expected value and address. Exactly one cycle later i_mem_rdata is compared, regardless of any stall in that cycle.
- On mismatch: o_err_count increments (saturating). The first mismatch since start latches bank/addr; later mismatches do not overwrite it.
- Host writes during a march may corrupt the pattern. The resulting mismatches are counted as normal.
- i_start while busy is ignored.
- i_abort while busy → IDLE next cycle: no o_done, pending compare dropped, results held.
- i_abort in IDLE has no effect.

## Timing
- Reset values:
  - o_busy=0, o_done=0, o_err_count=0, o_first_err_bank=0, o_first_err_addr=0.
  - State IDLE; o_bank_cs=0 unless i_host_req.
- o_busy rises the cycle after i_start and falls in the DONE cycle, coincident with the o_done pulse.
- With N = NUM_BANKS*512 and no stalls, o_done is asserted 6N+3 cycles after the i_start cycle.
- Each host-stall cycle adds exactly one cycle.
- o_err_count updates the cycle after the compare cycle. It is final when o_done is high.
- i_rst mid-march: IDLE next edge, all outputs to reset values, no o_done.

## Test plan
- NUM_BANKS=2, fault-free bank model, i_start → o_done exactly 6147 cycles later (N=1024), o_err_count=0, o_busy high throughout.
- Bank model with byte 1/0x0A7 stuck at 0x55 → err_count=1 (RW2 read expects 0xAA), first_err_bank=1, first_err_addr=0x0A7.
- i_host_req held 10 cycles mid-RW1 → host read of bank 0/0x000 returns the current pattern; march completes 10 cycles late with no errors. Also check a host request in the cycle between a march read and its compare.
- Host write 0x00 to bank 0/0x010 during W0 after that address is written → err_count ≥1, first_err at bank 0/0x010.
- i_abort at cycle 500 → o_busy=0 next cycle, no o_done. A following i_start runs a full march and clears o_err_count.
- i_rst during RW2 → all outputs reset next cycle; i_start during a busy march is ignored (completion time unchanged).
